pe_arr_drain: RTL and testbench

Result unloader for the systolic PE array. On a `capture` pulse it snapshots the array's flattened accumulator bus into a local register bank, then streams the values out one at a time in row-major order over a valid/ready handshake. The array can be cleared and refired while the drain is streaming. Sits between the PE array's `outs_port` and the result writeback path.

---
 rtl/pe_arr_drain_pkg.sv | 24 ++
 rtl/pe_arr_drain_if.sv | 38 +++
 rtl/drain_idx_ctr.sv | 47 ++++
 rtl/pe_arr_drain.sv | 108 ++++++++++
 tb/tb_pe_arr_drain.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_arr_drain_pkg.sv
// rtl/pe_arr_drain_pkg.sv - shared PE array defines: accumulator width and clog2 helper
// Purpose: constants and helpers shared by the PE array, its feeder and the result drain.
// Ports: none (package).
package pe_arr_drain_pkg;

   // Accumulator width of one PE, shared with the array and the feeder.
   localparam int DEF_ACC_W = 32;

   // Drain FSM encoding, kept as plain constants for legacy tooling.
   typedef logic [0:0] drain_state_t;
   localparam drain_state_t ST_IDLE   = 1'b0;
   localparam drain_state_t ST_STREAM = 1'b1;

   // ceil(log2(n)) but never below 1, so a dimension of 1 still gets a counter bit.
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/pe_arr_drain_if.sv
// rtl/pe_arr_drain_if.sv - result stream interface between the drain and writeback
// Purpose: groups the element stream handshake and its payload.
// Ports (master = drain): out_valid, out_data, out_row, out_col, out_last driven; out_ready sampled.
// Ports (slave = writeback): the mirror image.
interface pe_arr_drain_if
   import pe_arr_drain_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W,
   parameter int ROW_W = 4,
   parameter int COL_W = 4
) ();

   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [ROW_W-1:0] out_row;
   logic [COL_W-1:0] out_col;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_row,
      output out_col,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_row,
      input  out_col,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/drain_idx_ctr.sv
// rtl/drain_idx_ctr.sv - row/column index counter pair for the result drain
// Purpose: walks (row, col) in row-major order, one step per advance.
// Ports: clk, rstn (async active-low); clear (to 0,0, wins over advance); advance (step once);
//        row, col (current index); at_last (index is ROWS-1, COLS-1).
module drain_idx_ctr
   import pe_arr_drain_pkg::*;
#(
   parameter int ROWS = 16,
   parameter int COLS = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         clear,
   input  logic                         advance,
   output logic [clog2_min1(ROWS)-1:0]  row,
   output logic [clog2_min1(COLS)-1:0]  col,
   output logic                         at_last
);

   localparam int ROW_W = clog2_min1(ROWS);
   localparam int COL_W = clog2_min1(COLS);

   logic row_at_max;
   logic col_at_max;

   assign row_at_max = (row == ROW_W'(ROWS - 1));
   assign col_at_max = (col == COL_W'(COLS - 1));
   assign at_last    = row_at_max & col_at_max;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col_at_max) begin
            col <= '0;
            row <= row_at_max ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_arr_drain.sv
// rtl/pe_arr_drain.sv - PE array result unloader: snapshot then row-major stream
// Purpose: on capture, copies the flattened accumulator bus into a local bank and streams it
//          out one element per handshake, row-major, allowing the array to refire meanwhile.
// Ports: clk, rstn (async active-low); capture (snapshot request); outs_port (flattened array
//        results, element k = col + row*COLS at [ACC_W*k : ACC_W*(k+1)-1]); out_if (result
//        stream, master side); busy (snapshot not yet drained); done (pulse after final
//        handshake); overrun (sticky: a capture was rejected).
module pe_arr_drain
   import pe_arr_drain_pkg::*;
#(
   parameter int ROWS  = 16,
   parameter int COLS  = 16,
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          capture,
   input  logic [0:ACC_W*ROWS*COLS-1]    outs_port,
   pe_arr_drain_if.master                out_if,
   output logic                          busy,
   output logic                          done,
   output logic                          overrun
);

   localparam int ROW_W = clog2_min1(ROWS);
   localparam int COL_W = clog2_min1(COLS);

   drain_state_t     state;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             at_last;
   logic             stream;
   logic             hs;
   logic             final_hs;
   logic             accept;
   logic             reject;

   logic [ACC_W-1:0] bank [ROWS][COLS];

   assign stream   = (state == ST_STREAM);
   assign hs       = stream & out_if.out_ready;
   assign final_hs = hs & at_last;
   // A capture is only taken when nothing is pending: idle, or the very last element leaving.
   assign accept   = capture & (~stream | final_hs);
   assign reject   = capture & stream & ~final_hs;

   drain_idx_ctr #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_idx_ctr (
      .clk     (clk),
      .rstn    (rstn),
      .clear   (accept),
      .advance (hs),
      .row     (row),
      .col     (col),
      .at_last (at_last)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
      end else if (accept) begin
         state <= ST_STREAM;
      end else if (final_hs) begin
         state <= ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         done    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done <= final_hs;
         if (accept) begin
            overrun <= 1'b0;
         end else if (reject) begin
            overrun <= 1'b1;
         end
      end
   end

   // The port is ascending-indexed, so the lowest bit of each slice lands in the element MSB.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               bank[r][c] <= '0;
            end
         end
      end else if (accept) begin
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               bank[r][c] <= outs_port[ACC_W*(c + r*COLS) +: ACC_W];
            end
         end
      end
   end

   assign busy             = stream;
   assign out_if.out_valid = stream;
   assign out_if.out_data  = bank[row][col];
   assign out_if.out_row   = row;
   assign out_if.out_col   = col;
   assign out_if.out_last  = stream & at_last;

endmodule

// File: tb/tb_pe_arr_drain.sv
// tb/tb_pe_arr_drain.sv - scoreboard bench for pe_arr_drain on a 2x2 array
module tb_pe_arr_drain;

   localparam int ROWS  = 2;
   localparam int COLS  = 2;
   localparam int ACC_W = 32;
   localparam int N     = ROWS * COLS;
   localparam int PW    = ACC_W * N;

   typedef struct {
      logic [31:0] data;
      logic        row;
      logic        col;
      logic        last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          capture = 1'b0;
   logic [0:PW-1] outs_port = '0;
   logic          busy;
   logic          done;
   logic          overrun;

   exp_t          sbq[$];
   int            errors = 0;
   int            checks = 0;
   logic [31:0]   cur_vals [N];
   bit            exp_overrun = 1'b0;
   bit            done_exp = 1'b0;
   bit            pend;

   pe_arr_drain_if #(.ACC_W(ACC_W), .ROW_W(1), .COL_W(1)) sif ();

   pe_arr_drain #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .ACC_W (ACC_W)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .capture   (capture),
      .outs_port (outs_port),
      .out_if    (sif),
      .busy      (busy),
      .done      (done),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Element k sits at bits [32k : 32k+31]; its bit 31 is the lowest-numbered port bit.
   function automatic logic [0:PW-1] pack_vals();
      logic [0:PW-1] p;
      p = '0;
      for (int k = 0; k < N; k++) begin
         for (int b = 0; b < ACC_W; b++) begin
            p[ACC_W*k + b] = cur_vals[k][ACC_W-1-b];
         end
      end
      return p;
   endfunction

   task automatic set_vals(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d);
      cur_vals[0] = a;
      cur_vals[1] = b;
      cur_vals[2] = c;
      cur_vals[3] = d;
      outs_port   = pack_vals();
   endtask

   task automatic push_expected();
      exp_t e;
      for (int k = 0; k < N; k++) begin
         e.data = cur_vals[k];
         e.row  = 1'(k / COLS);
         e.col  = 1'(k % COLS);
         e.last = (k == N - 1);
         sbq.push_back(e);
      end
   endtask

   // Called just after a rising edge; drives one cycle and updates the model after the edge.
   task automatic step(input bit cap, input bit rdy);
      bit acc;
      capture       = cap;
      sif.out_ready = rdy;
      acc = cap && ((sbq.size() == 0) || (sbq.size() == 1 && rdy));
      @(posedge clk);
      #1;
      if (acc) begin
         push_expected();
         exp_overrun = 1'b0;
      end else if (cap) begin
         exp_overrun = 1'b1;
      end
      capture = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sbq.size() > 0 && n < 64) begin
         step(1'b0, 1'b1);
         n++;
      end
      chk("drain_timeout", 32'(sbq.size()), 32'd0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
   endtask

   // Monitor: checks flags every cycle and the presented element against the queue head.
   always @(negedge clk) begin
      chk("out_valid", 32'(sif.out_valid), 32'(sbq.size() > 0));
      chk("busy", 32'(busy), 32'(sbq.size() > 0));
      chk("done", 32'(done), 32'(done_exp));
      chk("overrun", 32'(overrun), 32'(exp_overrun));
      pend = 1'b0;
      if (sbq.size() > 0) begin
         chk("out_data", sif.out_data, sbq[0].data);
         chk("out_row", 32'(sif.out_row), 32'(sbq[0].row));
         chk("out_col", 32'(sif.out_col), 32'(sbq[0].col));
         chk("out_last", 32'(sif.out_last), 32'(sbq[0].last));
         if (sif.out_ready) begin
            pend = sbq[0].last;
            void'(sbq.pop_front());
         end
      end else begin
         chk("out_last_idle", 32'(sif.out_last), 32'd0);
      end
      if (!rstn) pend = 1'b0;
      done_exp = pend;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      int pat [7];
      pat = '{1, 0, 0, 1, 0, 1, 1};

      // Reset held with capture and an all-ones bus present.
      sif.out_ready = 1'b1;
      capture       = 1'b1;
      outs_port     = '1;
      rstn          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_data", sif.out_data, 32'd0);
      chk("rst_out_row", 32'(sif.out_row), 32'd0);
      chk("rst_out_col", 32'(sif.out_col), 32'd0);
      chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      capture = 1'b0;
      rstn    = 1'b1;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);

      // Basic drain at full throughput.
      set_vals(32'h11, 32'h22, 32'h33, 32'h44);
      step(1'b1, 1'b1);
      drain();

      // Backpressure pattern.
      step(1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, pat[i] != 0);
      drain();

      // Snapshot isolation: bus changes right after capture.
      step(1'b1, 1'b1);
      outs_port = '1;
      drain();

      // Overrun mid-stream, then back-to-back capture on the final handshake.
      set_vals(32'h11, 32'h22, 32'h33, 32'h44);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      set_vals(32'hA, 32'hB, 32'hC, 32'hD);
      step(1'b1, 1'b1);
      drain();

      // Randomized captures, values and backpressure.
      for (int i = 0; i < 300; i++) begin
         bit cap;
         bit rdy;
         cap = ($urandom_range(0, 4) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         if (cap) set_vals($urandom, $urandom, $urandom, $urandom);
         step(cap, rdy);
      end
      drain();

      // Asynchronous reset while element 2 is presented.
      set_vals($urandom, $urandom, $urandom, $urandom);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      rstn = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(sif.out_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_data", sif.out_data, 32'd0);
      sbq.delete();
      exp_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      repeat (4) step(1'b0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
